alu_booth_mult_sequencer: RTL and testbench

- Multicycle signed 32x32 multiplier with no multiplier array of its own; it reuses the shared 32-bit ALU (ADD = 5'd0, SUB = 5'd1) over 32 Booth radix-2 iterations.
- Sits beside the ALU in the execute stage. Requests ALU ownership from the execute-stage arbiter and stalls while not granted.
- Returns the low 32 bits of the product plus an overflow exception flag.

---
 rtl/alu_booth_mult_sequencer.sv | 115 +++++++++++
 tb/tb_alu_booth_mult_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_booth_mult_sequencer.sv
// Signed 32x32 Booth radix-2 multiplier that borrows the shared execute-stage ALU
// for one add/sub per iteration and returns the low product word plus an overflow flag.
module alu_booth_mult_sequencer #(
    parameter int ITERS = 32
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ctrl_MULT,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        alu_grant,
    output logic        alu_req,
    output logic [31:0] alu_operandA,
    output logic [31:0] alu_operandB,
    output logic [4:0]  alu_opcode,
    output logic [4:0]  alu_shamt,
    input  logic [31:0] alu_result,
    input  logic        alu_overflow,
    output logic        busy,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] mcand, p_hi, p_lo;
    logic        q_m1;
    logic [5:0]  count;

    logic        start, step, last, sign_bit;
    logic [31:0] p_hi_nxt, p_lo_nxt;

    assign start    = ctrl_MULT && (state != RUN);
    assign step     = (state == RUN) && alu_grant;
    assign last     = (count == 6'(ITERS - 1));
    // The ALU result is only 32 bits; XOR with overflow recovers the true 33-bit sign.
    assign sign_bit = alu_result[31] ^ alu_overflow;
    assign p_hi_nxt = {sign_bit, alu_result[31:1]};
    assign p_lo_nxt = {alu_result[0], p_lo[31:1]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = start ? RUN : IDLE;
            RUN:        if (step && last) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        alu_operandA = '0;
        alu_operandB = '0;
        alu_opcode   = OP_ADD;
        if (state == RUN) begin
            alu_operandA = p_hi;
            case ({p_lo[0], q_m1})
                2'b10: begin
                    alu_opcode   = OP_SUB;
                    alu_operandB = mcand;
                end
                2'b01:   alu_operandB = mcand;
                default: alu_operandB = '0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mcand          <= '0;
            p_hi           <= '0;
            p_lo           <= '0;
            q_m1           <= 1'b0;
            count          <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (start) begin
            mcand <= data_operandA;
            p_hi  <= '0;
            p_lo  <= data_operandB;
            q_m1  <= 1'b0;
            count <= '0;
        end else if (step) begin
            p_hi  <= p_hi_nxt;
            p_lo  <= p_lo_nxt;
            q_m1  <= p_lo[0];
            count <= count + 6'd1;
            if (last) begin
                data_result    <= p_lo_nxt;
                data_exception <= (p_hi_nxt != {32{p_lo_nxt[31]}});
            end
        end
    end

    assign busy           = (state == RUN);
    assign alu_req        = (state == RUN);
    assign data_resultRDY = (state == DONE);
    assign alu_shamt      = '0;

endmodule

// File: tb/tb_alu_booth_mult_sequencer.sv
// Bench for alu_booth_mult_sequencer: behavioural ALU, vector table, scoreboard queue
// of expected products, plus hand sequences for stall, ignored start and reset.
module tb_alu_booth_mult_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ctrl_MULT;
    logic [31:0] data_operandA, data_operandB;
    logic        alu_grant;
    logic        alu_req;
    logic [31:0] alu_operandA, alu_operandB;
    logic [4:0]  alu_opcode, alu_shamt;
    logic [31:0] alu_result;
    logic        alu_overflow;
    logic        busy;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    alu_booth_mult_sequencer dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .alu_grant      (alu_grant),
        .alu_req        (alu_req),
        .alu_operandA   (alu_operandA),
        .alu_operandB   (alu_operandB),
        .alu_opcode     (alu_opcode),
        .alu_shamt      (alu_shamt),
        .alu_result     (alu_result),
        .alu_overflow   (alu_overflow),
        .busy           (busy),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    // Shared ALU: ADD=0, SUB=1, signed overflow flag.
    always_comb begin
        if (alu_opcode == 5'd1) begin
            alu_result   = alu_operandA - alu_operandB;
            alu_overflow = (alu_operandA[31] != alu_operandB[31]) && (alu_result[31] != alu_operandA[31]);
        end else begin
            alu_result   = alu_operandA + alu_operandB;
            alu_overflow = (alu_operandA[31] == alu_operandB[31]) && (alu_result[31] != alu_operandA[31]);
        end
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_r;
        logic        exp_e;
        int          stall_at;
        int          stall_len;
        int          poke_at;
        bit          b2b;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] r;
        logic        e;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t   x;
        longint p;
        p   = longint'($signed(a)) * longint'($signed(b));
        x.r = p[31:0];
        x.e = (p != longint'($signed(p[31:0])));
        return x;
    endfunction

    // Called in the negedge region; returns at the negedge where RDY is seen.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input logic exp_e,
                          input int stall_at, input int stall_len, input int poke_at,
                          input string name);
        int   c;
        exp_t got;
        exp_q.push_back('{exp_r, exp_e});
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        c = 0;
        while (!data_resultRDY && c < 200) begin
            if (c == poke_at) begin
                ctrl_MULT     = 1'b1;
                data_operandA = ~a;
                data_operandB = b + 32'd7;
            end else begin
                ctrl_MULT = 1'b0;
            end
            alu_grant = !(stall_len > 0 && c >= stall_at && c < stall_at + stall_len);
            if (!alu_grant) begin
                check({name, " stall busy"}, {31'd0, busy}, 32'd1);
                check({name, " stall req"}, {31'd0, alu_req}, 32'd1);
            end
            @(negedge clock);
            c++;
        end
        ctrl_MULT = 1'b0;
        alu_grant = 1'b1;
        if (!data_resultRDY) begin
            check({name, " timeout rdy"}, {31'd0, data_resultRDY}, 32'd1);
        end else if (exp_q.size() == 0) begin
            check({name, " scoreboard empty"}, 32'd0, 32'd1);
        end else begin
            got = exp_q.pop_front();
            check({name, " result"}, data_result, got.r);
            check({name, " exception"}, {31'd0, data_exception}, {31'd0, got.e});
            check({name, " latency"}, c, 32'(32 + stall_len));
            check({name, " busy in done"}, {31'd0, busy}, 32'd0);
        end
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{32'd3,         32'd5,         32'd15,         1'b0, 0,  0, -1, 1'b0, "3x5"};
        vecs[1] = '{32'hFFFFFFF9,  32'd6,         32'hFFFFFFD6,   1'b0, 0,  0, -1, 1'b0, "m7x6"};
        vecs[2] = '{32'h80000000,  32'd1,         32'h80000000,   1'b0, 0,  0, -1, 1'b0, "minx1"};
        vecs[3] = '{32'h80000000,  32'hFFFFFFFF,  32'h80000000,   1'b1, 0,  0, -1, 1'b0, "minxm1"};
        vecs[4] = '{32'h00010000,  32'h00010000,  32'd0,          1'b1, 0,  0, -1, 1'b0, "2p16sq"};
        vecs[5] = '{32'd12,        32'hFFFFFFF4,  32'hFFFFFF70,   1'b0, 10, 5, -1, 1'b0, "stall"};
        vecs[6] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  32'd1,          1'b0, 0,  0, 4,  1'b0, "poke"};
        vecs[7] = '{32'h7FFFFFFF,  32'd2,         32'hFFFFFFFE,   1'b1, 0,  0, -1, 1'b1, "b2b"};

        reset_n       = 1'b0;
        ctrl_MULT     = 1'b0;
        alu_grant     = 1'b1;
        data_operandA = '0;
        data_operandB = '0;
        #12;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset req", {31'd0, alu_req}, 32'd0);
        check("reset rdy", {31'd0, data_resultRDY}, 32'd0);
        check("reset result", data_result, 32'd0);
        check("reset exception", {31'd0, data_exception}, 32'd0);
        check("reset opA", alu_operandA, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            if (!vecs[i].b2b) @(negedge clock);
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp_r, vecs[i].exp_e,
                   vecs[i].stall_at, vecs[i].stall_len, vecs[i].poke_at, vecs[i].name);
        end

        @(negedge clock);
        check("idle rdy", {31'd0, data_resultRDY}, 32'd0);
        check("idle busy", {31'd0, busy}, 32'd0);
        check("hold result", data_result, 32'hFFFFFFFE);
        check("hold exception", {31'd0, data_exception}, 32'd1);
        check("idle opA", alu_operandA, 32'd0);
        check("idle opB", alu_operandB, 32'd0);
        check("idle opcode", {27'd0, alu_opcode}, 32'd0);
        check("shamt", {27'd0, alu_shamt}, 32'd0);

        for (int i = 0; i < 4; i++) begin
            logic [31:0] ra, rb;
            exp_t        m;
            ra = $urandom;
            rb = (i < 2) ? $urandom_range(0, 65535) : $urandom;
            m  = model(ra, rb);
            @(negedge clock);
            run_op(ra, rb, m.r, m.e, 0, 0, -1, "random");
        end

        @(negedge clock);
        data_operandA = 32'h00001234;
        data_operandB = 32'h00005678;
        ctrl_MULT     = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        repeat (8) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("async rst busy", {31'd0, busy}, 32'd0);
        check("async rst req", {31'd0, alu_req}, 32'd0);
        check("async rst result", data_result, 32'd0);
        check("async rst rdy", {31'd0, data_resultRDY}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        run_op(32'd2, 32'hFFFFFFFD, 32'hFFFFFFFA, 1'b0, 0, 0, -1, "after reset");

        check("scoreboard drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
